load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use parameter WAIT_MAX, default 255, meaning cycles spent in REQ+RESP before timeout.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- ex_valid  in  1  execute-stage request
- ex_ready  out  1  LSU can accept a request
- ex_load, ex_store  in  1 each  access type, mutually exclusive
- ex_funct3  in  3  RV32I width/sign field
- ex_addr  in  32  effective address from ALU
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  load destination
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- done  out  1  one-cycle completion pulse
- wb_we, wb_rd, wb_data  out  1/5/32  register writeback
- err  out  1  one-cycle error pulse
- err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout

Function
REQ-004 ex_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with ex_valid=1, ex_ready=1, and all ex_* fields are registered on acceptance.
REQ-005 FSM states SHALL be IDLE, REQ, RESP, FIN. IDLE->REQ on acceptance. REQ->RESP on mem_gnt for loads, REQ->FIN on mem_gnt for stores. RESP->FIN on mem_rvalid. FIN->IDLE unconditionally.
REQ-006 mem_req SHALL be 1 exactly while in REQ, with mem_addr, mem_we, mem_be, and mem_wdata stable until mem_gnt.
REQ-007 Legal loads SHALL be LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores SHALL be SB 000, SH 001, SW 010. Any other funct3 SHALL produce err with err_code 10, with no memory access.
REQ-008 A halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL produce err with err_code 01, with no memory access. Illegal funct3 SHALL take priority over misalignment.
REQ-009 Error pulses SHALL occur in the cycle after acceptance, with done=0 and wb_we=0; the FSM returns directly to IDLE.
REQ-010 Store byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111. mem_wdata SHALL replicate the byte or halfword into all lanes.
REQ-011 Loads SHALL select the byte or halfword by addr[1:0]. LB and LH are sign-extended; LBU and LHU are zero-extended.
REQ-012 In FIN, done=1 for one cycle. For loads, wb_we=1, wb_rd is the captured rd, and wb_data is the aligned data registered from mem_rdata. For stores, wb_we=0.
REQ-013 Latency: for acceptance at T, gnt at T+1, and rvalid at T+2, a load's done SHALL occur at T+3. For a store with gnt at T+1, done SHALL occur at T+2.
REQ-014 mem_rvalid SHALL be ignored outside RESP, including rvalid in the same cycle as gnt and stale rvalid in IDLE.
REQ-015 A wait counter SHALL clear on entering REQ and increment each cycle in REQ or RESP. On reaching WAIT_MAX, the block SHALL drop mem_req, pulse err with err_code 11, and return to IDLE without done.

Reset
REQ-016 While rst=0, the state SHALL be IDLE, the counter 0, and all outputs 0 (including ex_ready and mem_req). ex_ready SHALL rise on the first clock edge after release.
REQ-017 Reset asserted mid-transaction SHALL abort immediately: mem_req drops asynchronously and no done, err, or wb_we is issued.

Structure
REQ-018 Package rv32_pkg SHALL hold the funct3 load/store encodings, the LSU state enum, and the err_code constants.
REQ-019 Load extraction and sign/zero extension SHALL live in a combinational sub-module named load_align.

Verification
REQ-020 LB at addr 0x103 with mem_rdata 0x80FF_1234 -> wb_data 0xFFFF_FF80, wb_we=1, done at T+3.
REQ-021 SH at addr 0x202 with ex_wdata 0x0000_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x200, done at T+2.
REQ-022 LW at addr 0x101 -> err=1 with err_code 01 at T+1, mem_req never asserted.
REQ-023 Load with funct3 011 -> err_code 10. Store with funct3 100 -> err_code 10.
REQ-024 mem_gnt held 0 with WAIT_MAX=8 -> err_code 11 after 8 REQ cycles, mem_req=0, ex_ready=1 next cycle.
REQ-025 rst pulled low in RESP, then a late mem_rvalid -> no wb_we, outputs 0, and a new LBU is accepted correctly after release.

Source files
------------

// File: rtl/rv32_pkg.sv
// ============================================================================
// Module  : rv32_pkg
// Brief   : RV32I load/store encodings, LSU state type and error codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_FIN  = 2'd3
    } lsu_state_t;

    // Classifies a request; an illegal funct3 wins over misalignment.
    function automatic logic [1:0] lsu_check(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic legal;
        legal = 1'b0;
        if (is_load) begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                default:                             legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: legal = 1'b1;
                default:             legal = 1'b0;
            endcase
        end
        if (!legal)
            return ERR_FUNCT3;
        if ((funct3[1:0] == 2'b01 && addr_lo[0]) ||
            (funct3[1:0] == 2'b10 && addr_lo != 2'b00))
            return ERR_MISALIGN;
        return ERR_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module  : load_align
// Brief   : Selects the addressed byte/halfword of a read word and extends it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : RV32I load/store unit with request/grant/rvalid memory handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    lsu_state_t       state, state_next;
    logic             ready_q;
    logic             accept, timeout;
    logic [1:0]       req_code;
    logic             req_err;
    logic [CNT_W-1:0] cnt;

    logic             is_load_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [4:0]       rd_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q, wdata_q, wb_data_q;
    logic             we_q, err_q;
    logic [1:0]       err_code_q;

    logic [3:0]       be_n;
    logic [31:0]      wdata_n, aligned;

    assign req_code = lsu_check(ex_load, ex_store, ex_funct3, ex_addr[1:0]);
    assign req_err  = (req_code != ERR_NONE);

    always_comb begin
        be_n    = 4'b0000;
        wdata_n = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << ex_addr[1:0];
                wdata_n = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{ex_wdata[15:0]}};
            end
            2'b10:   be_n = 4'b1111;
            default: be_n = 4'b0000;
        endcase
    end

    load_align u_load_align (
        .funct3  (funct3_q),
        .addr_lo (off_q),
        .rdata   (mem_rdata),
        .data    (aligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Grant/rvalid win over a timeout that lands in the same cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ex_valid && ready_q) begin
                    accept = 1'b1;
                    if (!req_err)
                        state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt)
                    state_next = is_load_q ? ST_RESP : ST_FIN;
                else if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                    timeout    = 1'b1;
                end
            end
            ST_RESP: begin
                if (mem_rvalid)
                    state_next = ST_FIN;
                else if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                    timeout    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= 1'b0;
            cnt        <= '0;
            is_load_q  <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            be_q       <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            wb_data_q  <= 32'd0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            if (accept) begin
                cnt <= '0;
                if (req_err) begin
                    err_q      <= 1'b1;
                    err_code_q <= req_code;
                end else begin
                    is_load_q <= ex_load;
                    funct3_q  <= ex_funct3;
                    off_q     <= ex_addr[1:0];
                    rd_q      <= ex_rd;
                    be_q      <= be_n;
                    addr_q    <= {ex_addr[31:2], 2'b00};
                    wdata_q   <= wdata_n;
                    we_q      <= ex_store;
                end
            end else if (state == ST_REQ || state == ST_RESP) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (timeout) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end
            if (state == ST_RESP && mem_rvalid)
                wb_data_q <= aligned;
        end
    end

    assign ex_ready  = ready_q && (state == ST_IDLE);
    assign mem_req   = (state == ST_REQ);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state == ST_FIN);
    assign wb_we     = (state == ST_FIN) && is_load_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed self-checking bench for load_store_unit (WAIT_MAX = 8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        done, wb_we, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WAIT_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_load    (ex_load),
        .ex_store   (ex_store),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at T+1.
    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        ex_valid  = 1'b1;
        ex_load   = ld;
        ex_store  = ~ld;
        ex_funct3 = f3;
        ex_addr   = addr;
        ex_wdata  = wd;
        ex_rd     = rd;
        tick();
        ex_valid  = 1'b0;
        ex_load   = 1'b0;
        ex_store  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

        tick(); tick();
        chk("rst_ex_ready", ex_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wb_we", wb_we, 0);
        rst = 1'b1;
        #1 chk("release_ready_before_edge", ex_ready, 0);
        tick();
        chk("release_ready_after_edge", ex_ready, 1);

        // LB at 0x103, byte 0x80 sign-extended
        issue(1'b1, 3'b000, 32'h0000_0103, 32'd0, 5'd5);
        chk("lb_req", mem_req, 1);
        chk("lb_addr", mem_addr, 32'h0000_0100);
        chk("lb_we", mem_we, 0);
        chk("lb_ready_busy", ex_ready, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("lb_req_after_gnt", mem_req, 0);
        chk("lb_done_early", done, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
        tick();
        mem_rvalid = 1'b0;
        chk("lb_done_t3", done, 1);
        chk("lb_wb_we", wb_we, 1);
        chk("lb_wb_rd", wb_rd, 5);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        tick();
        chk("lb_done_one_cycle", done, 0);
        chk("lb_ready_back", ex_ready, 1);

        // SH at 0x202
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0);
        chk("sh_req", mem_req, 1);
        chk("sh_we", mem_we, 1);
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", mem_addr, 32'h0000_0200);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("sh_done_t2", done, 1);
        chk("sh_wb_we", wb_we, 0);
        tick();

        // SB at 0x001 with grant delayed one cycle
        issue(1'b0, 3'b000, 32'h0000_0001, 32'h1234_5677, 5'd0);
        chk("sb_be", mem_be, 4'b0010);
        chk("sb_wdata", mem_wdata, 32'h7777_7777);
        tick();
        chk("sb_req_held", mem_req, 1);
        chk("sb_be_stable", mem_be, 4'b0010);
        chk("sb_done_wait", done, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("sb_done", done, 1);
        tick();

        // LW misaligned
        issue(1'b1, 3'b010, 32'h0000_0101, 32'd0, 5'd3);
        chk("lw_mis_err", err, 1);
        chk("lw_mis_code", err_code, 2'b01);
        chk("lw_mis_req", mem_req, 0);
        chk("lw_mis_done", done, 0);
        chk("lw_mis_wb_we", wb_we, 0);
        tick();
        chk("lw_mis_req_later", mem_req, 0);
        chk("lw_mis_err_pulse", err, 0);

        // Illegal funct3, including priority over misalignment
        issue(1'b1, 3'b011, 32'h0000_0000, 32'd0, 5'd1);
        chk("ld_f3_011_code", err_code, 2'b10);
        chk("ld_f3_011_req", mem_req, 0);
        issue(1'b0, 3'b100, 32'h0000_0000, 32'd0, 5'd0);
        chk("st_f3_100_err", err, 1);
        chk("st_f3_100_code", err_code, 2'b10);
        issue(1'b0, 3'b101, 32'h0000_0001, 32'd0, 5'd0);
        chk("prio_code", err_code, 2'b10);
        tick();

        // Stale rvalid in IDLE must do nothing
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("stale_rvalid_done", done, 0);
        chk("stale_rvalid_wb_we", wb_we, 0);

        // LH at 0x000, rvalid alongside gnt must be ignored
        issue(1'b1, 3'b001, 32'h0000_0000, 32'd0, 5'd9);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("lh_wait_rvalid", done, 0);
        tick();
        chk("lh_still_waiting", done, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("lh_done", done, 1);
        chk("lh_wb_data", wb_data, 32'hFFFF_F00D);
        chk("lh_wb_rd", wb_rd, 9);
        tick();

        // LHU at 0x102, upper halfword zero-extended
        issue(1'b1, 3'b101, 32'h0000_0102, 32'd0, 5'd4);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h8765_4321;
        tick();
        mem_rvalid = 1'b0;
        chk("lhu_wb_data", wb_data, 32'h0000_8765);
        tick();

        // Timeout with grant held low: eight REQ cycles, then error
        issue(1'b1, 3'b010, 32'h0000_0040, 32'd0, 5'd2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_req_cycle%0d", i), mem_req, 1);
            tick();
        end
        chk("to_req_dropped", mem_req, 0);
        chk("to_err", err, 1);
        chk("to_code", err_code, 2'b11);
        chk("to_done", done, 0);
        chk("to_ready", ex_ready, 1);
        tick();

        // Reset during RESP, then a late rvalid
        issue(1'b1, 3'b000, 32'h0000_0000, 32'd0, 5'd7);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_ready", ex_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_wb_data", wb_data, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA;
        tick();
        mem_rvalid = 1'b0;
        chk("abort_late_wb_we", wb_we, 0);
        chk("abort_late_done", done, 0);
        rst = 1'b1;
        tick();
        chk("abort_ready_again", ex_ready, 1);

        // LBU at 0x101 after recovery
        issue(1'b1, 3'b100, 32'h0000_0101, 32'd0, 5'd11);
        chk("lbu_req", mem_req, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_9C00;
        tick();
        mem_rvalid = 1'b0;
        chk("lbu_done", done, 1);
        chk("lbu_wb_we", wb_we, 1);
        chk("lbu_wb_rd", wb_rd, 11);
        chk("lbu_wb_data", wb_data, 32'h0000_009C);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
